// File: rtl/ex_mem_seg.sv
// EX/MEM pipeline segment: registers ALU results and control, aligns store data,
// and holds the stage while a variable-latency data-memory access is outstanding.
module ex_mem_seg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       alu_out_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic [1:0]            store_type_i,
  input  logic [2:0]            load_type_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic                  mem_ack,
  output logic                  mem_valid_o,
  output logic [XLEN-1:0]       alu_out_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic [3:0]            wbe_o,
  output logic                  mem_req_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic [2:0]            load_type_o,
  output logic [XLEN-1:0]       pc_o,
  output logic                  stall_out
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;

  state_t state;

  function automatic logic [XLEN-1:0] align_wdata(input logic [1:0] st,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = d;
    case (st)
      ST_SB:   r = {(XLEN/8){d[7:0]}};
      ST_SH:   r = {(XLEN/16){d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] st, input logic [1:0] off);
    logic [3:0] r;
    case (st)
      ST_NONE: r = 4'b0000;
      ST_SB:   r = 4'b0001 << off;
      ST_SH:   r = 4'b0011 << {off[1], 1'b0};
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // EX-side decode (p0): what would be latched this edge.
  logic            stall_int;
  logic            load_p0;
  logic            bubble_p0;
  logic            is_mem_p0;
  logic [XLEN-1:0] wdata_p0;
  logic [3:0]      wbe_p0;

  // A pending access cannot be killed, so the stall also blocks a flush.
  assign stall_int = (state == WAIT) && !mem_ack;
  assign stall_out = stall_int;
  assign load_p0   = (en || clear) && !stall_int;
  assign bubble_p0 = clear || !ex_valid;
  assign is_mem_p0 = mem_read_i || (store_type_i != ST_NONE);
  assign wdata_p0  = align_wdata(store_type_i, rs2_data_i);
  assign wbe_p0    = byte_en(store_type_i, alu_out_i[1:0]);

  // MEM-side registers (p1) and access FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_valid_o <= 1'b0;
      alu_out_o   <= '0;
      wdata_o     <= '0;
      wbe_o       <= 4'b0000;
      mem_req_o   <= 1'b0;
      rd_o        <= '0;
      reg_write_o <= 1'b0;
      mem_read_o  <= 1'b0;
      load_type_o <= '0;
      pc_o        <= '0;
    end else if (load_p0) begin
      if (bubble_p0) begin
        state       <= IDLE;
        mem_valid_o <= 1'b0;
        alu_out_o   <= '0;
        wdata_o     <= '0;
        wbe_o       <= 4'b0000;
        mem_req_o   <= 1'b0;
        rd_o        <= '0;
        reg_write_o <= 1'b0;
        mem_read_o  <= 1'b0;
        load_type_o <= '0;
        pc_o        <= '0;
      end else begin
        state       <= is_mem_p0 ? WAIT : IDLE;
        mem_valid_o <= 1'b1;
        alu_out_o   <= alu_out_i;
        wdata_o     <= wdata_p0;
        wbe_o       <= wbe_p0;
        mem_req_o   <= is_mem_p0;
        rd_o        <= rd_i;
        reg_write_o <= reg_write_i;
        mem_read_o  <= mem_read_i;
        load_type_o <= load_type_i;
        pc_o        <= pc_i;
      end
    end else if ((state == WAIT) && mem_ack) begin
      state     <= IDLE;
      mem_req_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_seg.sv
// Directed bench for ex_mem_seg: flow-through, store alignment, wait states,
// flush priority, back-to-back access and reset during an outstanding access.
module tb_ex_mem_seg;

  logic        clk = 1'b0;
  logic        rst_n, en, clear, ex_valid, reg_write_i, mem_read_i, mem_ack;
  logic [31:0] alu_out_i, rs2_data_i, pc_i;
  logic [4:0]  rd_i;
  logic [1:0]  store_type_i;
  logic [2:0]  load_type_i;
  logic        mem_valid_o, mem_req_o, reg_write_o, mem_read_o, stall_out;
  logic [31:0] alu_out_o, wdata_o, pc_o;
  logic [3:0]  wbe_o;
  logic [4:0]  rd_o;
  logic [2:0]  load_type_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem_seg #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .ex_valid(ex_valid),
    .alu_out_i(alu_out_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .store_type_i(store_type_i), .load_type_i(load_type_i), .pc_i(pc_i),
    .mem_ack(mem_ack), .mem_valid_o(mem_valid_o), .alu_out_o(alu_out_o),
    .wdata_o(wdata_o), .wbe_o(wbe_o), .mem_req_o(mem_req_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .load_type_o(load_type_o), .pc_o(pc_o), .stall_out(stall_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [1:0] st, input logic [2:0] lt, input logic [31:0] pc);
    ex_valid = v; alu_out_i = alu; rs2_data_i = rs2; rd_i = rd; reg_write_i = rw;
    mem_read_i = mr; store_type_i = st; load_type_i = lt; pc_i = pc;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; mem_ack = 1'b0;
    set_inst(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0, 32'h0);
    #12;
    chk("rst_valid", {31'b0, mem_valid_o}, 32'h0);
    chk("rst_wbe", {28'b0, wbe_o}, 32'h0);
    chk("rst_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_alu", alu_out_o, 32'h0);
    rst_n = 1'b1;
    en = 1'b1;
    #3;

    // ADD flows through in one cycle
    set_inst(1'b1, 32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 3'd0, 32'h100);
    tick();
    chk("add_alu", alu_out_o, 32'h10);
    chk("add_rd", {27'b0, rd_o}, 32'd5);
    chk("add_rw", {31'b0, reg_write_o}, 32'd1);
    chk("add_valid", {31'b0, mem_valid_o}, 32'd1);
    chk("add_pc", pc_o, 32'h100);
    chk("add_req", {31'b0, mem_req_o}, 32'd0);
    chk("add_stall", {31'b0, stall_out}, 32'd0);

    // SB at offset 3
    set_inst(1'b1, 32'h0000_1003, 32'h1234_56AB, 5'd0, 1'b0, 1'b0, 2'b01, 3'd0, 32'h104);
    tick();
    chk("sb_wdata", wdata_o, 32'hABAB_ABAB);
    chk("sb_wbe", {28'b0, wbe_o}, 32'h8);
    chk("sb_req", {31'b0, mem_req_o}, 32'd1);
    chk("sb_stall", {31'b0, stall_out}, 32'd1);

    // SH at offset 2 latched on the SB ack cycle (back-to-back)
    set_inst(1'b1, 32'h0000_2002, 32'h0000_BEEF, 5'd0, 1'b0, 1'b0, 2'b10, 3'd0, 32'h108);
    mem_ack = 1'b1;
    #1;
    chk("ack_nostall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("sh_wdata", wdata_o, 32'hBEEF_BEEF);
    chk("sh_wbe", {28'b0, wbe_o}, 32'hC);
    chk("b2b_req", {31'b0, mem_req_o}, 32'd1);

    // Ack the SH while a bubble enters
    set_inst(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0, 32'h0);
    tick();
    chk("bub_req", {31'b0, mem_req_o}, 32'd0);
    chk("bub_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("bub_wbe", {28'b0, wbe_o}, 32'h0);
    mem_ack = 1'b0;

    // LW with three wait states
    set_inst(1'b1, 32'h0000_3000, 32'h0, 5'd7, 1'b1, 1'b1, 2'b00, 3'b010, 32'h10C);
    tick();
    chk("lw_mr", {31'b0, mem_read_o}, 32'd1);
    chk("lw_req", {31'b0, mem_req_o}, 32'd1);
    chk("lw_lt", {29'b0, load_type_o}, 32'd2);
    chk("lw_wbe", {28'b0, wbe_o}, 32'h0);
    set_inst(1'b1, 32'h0000_0044, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 3'd0, 32'h110);
    for (int i = 0; i < 3; i++) begin
      chk("wait_stall", {31'b0, stall_out}, 32'd1);
      tick();
      chk("wait_alu", alu_out_o, 32'h3000);
      chk("wait_rd", {27'b0, rd_o}, 32'd7);
    end
    mem_ack = 1'b1;
    #1;
    chk("lw_ack_stall", {31'b0, stall_out}, 32'd0);
    tick();
    chk("next_alu", alu_out_o, 32'h44);
    chk("next_rd", {27'b0, rd_o}, 32'd9);
    chk("next_req", {31'b0, mem_req_o}, 32'd0);
    mem_ack = 1'b0;

    // Flush beats a valid SW
    clear = 1'b1;
    set_inst(1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 2'b11, 3'd0, 32'h114);
    tick();
    chk("flush_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("flush_wbe", {28'b0, wbe_o}, 32'h0);
    chk("flush_req", {31'b0, mem_req_o}, 32'd0);
    chk("flush_stall", {31'b0, stall_out}, 32'd0);
    clear = 1'b0;
    tick();
    chk("sw_wdata", wdata_o, 32'hDEAD_BEEF);
    chk("sw_wbe", {28'b0, wbe_o}, 32'hF);
    chk("sw_stall", {31'b0, stall_out}, 32'd1);

    // Second SW latched on the ack cycle keeps WAIT
    set_inst(1'b1, 32'h0000_4004, 32'h0102_0304, 5'd0, 1'b0, 1'b0, 2'b11, 3'd0, 32'h118);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    set_inst(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'd0, 32'h0);
    #1;
    chk("sw2_wdata", wdata_o, 32'h0102_0304);
    chk("sw2_req", {31'b0, mem_req_o}, 32'd1);
    chk("sw2_wait", {31'b0, stall_out}, 32'd1);

    // Reset abandons the outstanding access
    tick();
    tick();
    chk("pre_rst_req", {31'b0, mem_req_o}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_req", {31'b0, mem_req_o}, 32'd0);
    chk("arst_wbe", {28'b0, wbe_o}, 32'h0);
    chk("arst_alu", alu_out_o, 32'h0);
    chk("arst_stall", {31'b0, stall_out}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'b0, stall_out}, 32'd0);
    chk("post_rst_req", {31'b0, mem_req_o}, 32'd0);

    // en=0 holds the segment
    set_inst(1'b1, 32'h0000_0055, 32'h0, 5'd3, 1'b1, 1'b0, 2'b00, 3'd0, 32'h200);
    tick();
    chk("en_load", alu_out_o, 32'h55);
    en = 1'b0;
    set_inst(1'b1, 32'h0000_0066, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 3'd0, 32'h204);
    tick();
    chk("en_hold_alu", alu_out_o, 32'h55);
    chk("en_hold_rd", {27'b0, rd_o}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
